pipe_stage3: RTL and testbench
==============================

# pipe_stage3

Reconfigurable multiply-accumulate stage directly downstream of `pipe_stage2`. It consumes the operand pairs that stage 2 emits (`operand1_o`/`operand2_o`, `mode`, `stage`, `finished`) and forms one signed product per pair: a single full-width product, or two packed half-width products. Products are accumulated with saturation until the `finished` pair of each vector arrives. Each completed dot product is then buffered in a 2-entry output FIFO with its stage tag and overflow flag, and backpressure is returned to stage 2 via `stall_o`.

## Interface
- `DATA_W`, 16: operand width; must be even.
- `ACC_W`, 40: accumulator/result width; must be ≥ 2*DATA_W.
- `STAGE_W`, 4: stage tag width.

- `CLK_i`  in  1  sole clock, rising edge.
- `RST_i`  in  1  asynchronous, active-high reset.
- `valid_i`  in  1  operand pair valid.
- `operand1_i`  in  DATA_W  signed operand A.
- `operand2_i`  in  DATA_W  signed operand B.
- `mode_i`  in  1  reconfig-tile mode, sampled per pair. 0 = full-width product A*B. 1 = dual product A[hi]*B[hi] + A[lo]*B[lo], with each half signed DATA_W/2.
- `stage_i`  in  STAGE_W  stage tag of the pair.
- `finished_i`  in  1  last pair of the current vector.
- `stall_i`  in  1  downstream cannot take a result this cycle.
- `stall_o`  out  1  backpressure to `pipe_stage2`; a pair is accepted only when `valid_i && !stall_o`.
- `result_o`  out  ACC_W  signed dot product at the FIFO head.
- `result_valid_o`  out  1  FIFO non-empty.
- `result_stage_o`  out  STAGE_W  tag of the `finished` pair that closed the vector.
- `overflow_o`  out  1  saturation occurred anywhere in this vector.
- `busy_o`  out  1  `state==ACCUM || s1_valid || result_valid_o`.

## Operation
- **S1, product register.** An accepted pair registers the following, each sign-extended to ACC_W:
  - the product (mode 0: 2*DATA_W bits; mode 1: sum of two DATA_W-bit products),
  - `s1_valid`, `s1_fin`, `s1_stage`.
- **S2, accumulate.** When `s1_valid` is set:
  - `sum = (state==IDLE ? 0 : acc) + prod`, computed at ACC_W+1 bits.
  - Clamp the sum to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - `ovf_acc |= clamped`.
- **FSM.**
  - IDLE→ACCUM on a non-finished S1 beat.
  - ACCUM→IDLE on a finished S1 beat.
  - A finished beat in IDLE (single-pair vector) stays in IDLE.
  - A finished beat pushes {clamped sum, `s1_stage`, `ovf_acc | clamped`} into the FIFO, then clears `acc` and `ovf_acc`.
- **FIFO.** 2 entries, with `result_*` driven from the head.
  - Pop = `result_valid_o && !stall_i`.
  - Push and pop in the same cycle are both honoured.
- **Credit rule.** `stall_o = (count + s1_fin - pop) >= 2`.
  - This rule guarantees the FIFO never overflows; no push is ever dropped.
  - `stall_o` is combinational from `stall_i`.
  - `stall_o` is independent of `valid_i` and `finished_i`.
- `stall_i` never freezes S1 or S2; only the FIFO stalls.
- `mode_i` may change between pairs of one vector; each product uses its own pair's mode.

## Timing
- Reset, asynchronous: every output is 0. Internal state is cleared: state=IDLE, acc=0, FIFO count=0, `s1_valid`=0.
- Reset mid-vector discards the partial sum. No residue survives into the next vector.
- Latency: a finished pair accepted in cycle k has `result_valid_o` high in cycle k+2.
- Throughput: one pair per cycle. With `stall_i` low, back-to-back single-pair vectors give one result per cycle and `stall_o` stays low.
- With `stall_i` held high: at most 2 results are buffered plus 1 non-finished S1 beat, and `stall_o` asserts as soon as count+`s1_fin` reaches 2.
- Results leave in vector order. Head outputs hold stable while `stall_i` is high.

## Structure
- Package `dal_pkg`:
  - `tile_mode_e` enum: `MODE_FULL`=0, `MODE_DUAL`=1.
  - `p3_state_e` enum: IDLE, ACCUM.
  - Default width constants.
  - Result-entry struct: {result, stage, ovf}.
- Sub-module `reconfig_mul`: combinational mode-selected signed product, DATA_W → ACC_W. The FIFO and FSM stay inline.

## Test plan
- **Full-mode vector.** mode 0, pairs (3,4), (-2,5), (7,7), finished on the third, stage=5 → `result_o`=51 and `result_stage_o`=5, 2 cycles after the third pair; `overflow_o`=0.
- **Dual-mode product.** mode 1, single finished pair 0x0203 × 0x0405 → 2*4 + 3*5 = 23. Also 0xFF03 × 0x0205 → -2+15 = 13.
- **Backpressure.** `stall_i`=1; three single-pair vectors → two results buffered, `stall_o`=1, third pair held off. Release `stall_i` → three results in order, nothing lost.
- **Saturation.** ACC_W=32; three pairs of 0x7FFF × 0x7FFF, last one finished → `result_o`=0x7FFFFFFF, `overflow_o`=1. The next vector (1,1) finished → 1 with `overflow_o`=0.
- **Reset mid-vector.** Two non-finished pairs, then pulse `RST_i` → all outputs 0. Then (1,1) finished → `result_o`=1.
- **Full rate.** 8 consecutive finished pairs (i, 1), i=0..7, with `stall_i`=0 → results 0..7 on consecutive cycles, `stall_o` never high.

Source files
------------

// File: rtl/dal_pkg.sv
// ============================================================================
// Module      : dal_pkg
// Description : Shared types and default widths for the dot-product
//               accumulate stage (pipe_stage3) and its multiplier tile.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dal_pkg;

    // Default widths; the top-level parameters fall back to these.
    localparam int C_DATA_W  = 16;
    localparam int C_ACC_W   = 40;
    localparam int C_STAGE_W = 4;

    // Multiplier tile configuration, sampled per operand pair.
    typedef enum logic [0:0] {
        MODE_FULL = 1'b0,
        MODE_DUAL = 1'b1
    } tile_mode_e;

    // Accumulator FSM: IDLE means the next beat starts a fresh vector.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } p3_state_e;

    // One completed dot product as held in the output FIFO (default widths).
    typedef struct packed {
        logic [C_ACC_W-1:0]   result;
        logic [C_STAGE_W-1:0] stage;
        logic                 ovf;
    } result_entry_t;

endpackage

`default_nettype wire

// File: rtl/reconfig_mul.sv
// ============================================================================
// Module      : reconfig_mul
// Description : Combinational signed multiplier tile. Full mode forms A*B;
//               dual mode forms A[hi]*B[hi] + A[lo]*B[lo] on signed halves.
//               Result is sign-extended to ACC_W.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reconfig_mul
    import dal_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int ACC_W  = C_ACC_W
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_mode,
    output logic [ACC_W-1:0]  o_prod
);

    localparam int HALF_W = DATA_W / 2;

    logic signed [DATA_W-1:0]   w_a;
    logic signed [DATA_W-1:0]   w_b;
    logic signed [HALF_W-1:0]   w_a_hi;
    logic signed [HALF_W-1:0]   w_a_lo;
    logic signed [HALF_W-1:0]   w_b_hi;
    logic signed [HALF_W-1:0]   w_b_lo;
    logic signed [2*DATA_W-1:0] w_full;
    logic signed [DATA_W-1:0]   w_p_hi;
    logic signed [DATA_W-1:0]   w_p_lo;
    logic signed [DATA_W:0]     w_dual;

    // Both products are formed every cycle; the mode bit only selects one.
    // The dual sum carries one extra bit because (-2^(H-1))^2 * 2 does not
    // fit in DATA_W signed bits.
    always_comb begin
        w_a    = i_a;
        w_b    = i_b;
        w_a_hi = i_a[DATA_W-1:HALF_W];
        w_a_lo = i_a[HALF_W-1:0];
        w_b_hi = i_b[DATA_W-1:HALF_W];
        w_b_lo = i_b[HALF_W-1:0];
        w_full = (2*DATA_W)'(w_a) * (2*DATA_W)'(w_b);
        w_p_hi = DATA_W'(w_a_hi) * DATA_W'(w_b_hi);
        w_p_lo = DATA_W'(w_a_lo) * DATA_W'(w_b_lo);
        w_dual = (DATA_W+1)'(w_p_hi) + (DATA_W+1)'(w_p_lo);
        if (i_mode == MODE_DUAL) begin
            o_prod = ACC_W'(w_dual);
        end else begin
            o_prod = ACC_W'(w_full);
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_stage3.sv
// ============================================================================
// Module      : pipe_stage3
// Description : Reconfigurable multiply-accumulate stage. Registers one signed
//               product per accepted pair, accumulates with saturation until
//               the finished pair, and buffers each dot product in a 2-entry
//               FIFO with credit-based backpressure towards pipe_stage2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage3
    import dal_pkg::*;
#(
    parameter int DATA_W  = C_DATA_W,
    parameter int ACC_W   = C_ACC_W,
    parameter int STAGE_W = C_STAGE_W
) (
    input  logic               CLK_i,
    input  logic               RST_i,
    input  logic               valid_i,
    input  logic [DATA_W-1:0]  operand1_i,
    input  logic [DATA_W-1:0]  operand2_i,
    input  logic               mode_i,
    input  logic [STAGE_W-1:0] stage_i,
    input  logic               finished_i,
    input  logic               stall_i,
    output logic               stall_o,
    output logic [ACC_W-1:0]   result_o,
    output logic               result_valid_o,
    output logic [STAGE_W-1:0] result_stage_o,
    output logic               overflow_o,
    output logic               busy_o
);

    localparam logic [ACC_W-1:0] C_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] C_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // S1 product register
    logic               s1_valid_q, s1_valid_d;
    logic               s1_fin_q,   s1_fin_d;
    logic [STAGE_W-1:0] s1_stage_q, s1_stage_d;
    logic [ACC_W-1:0]   s1_prod_q,  s1_prod_d;

    // S2 accumulator
    p3_state_e          state_q, state_d;
    logic [ACC_W-1:0]   acc_q,   acc_d;
    logic               ovf_q,   ovf_d;

    // Output FIFO
    logic [ACC_W-1:0]   fifo_res_q [2];
    logic [ACC_W-1:0]   fifo_res_d [2];
    logic [STAGE_W-1:0] fifo_stg_q [2];
    logic [STAGE_W-1:0] fifo_stg_d [2];
    logic               fifo_ovf_q [2];
    logic               fifo_ovf_d [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q,  count_d;

    logic [ACC_W-1:0]   w_prod;
    logic               w_accept;
    logic [ACC_W-1:0]   w_base;
    logic [ACC_W:0]     w_sum;
    logic               w_clamped;
    logic [ACC_W-1:0]   w_sat;
    logic               w_push;
    logic               w_pop;
    logic [2:0]         w_credit;

    reconfig_mul #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mul (
        .i_a    (operand1_i),
        .i_b    (operand2_i),
        .i_mode (mode_i),
        .o_prod (w_prod)
    );

    // Handshake, credit-based stall and FIFO head outputs.
    always_comb begin
        w_pop          = (count_q != 2'd0) && !stall_i;
        w_credit       = {1'b0, count_q} + {2'b00, s1_fin_q} - {2'b00, w_pop};
        stall_o        = (w_credit >= 3'd2);
        w_accept       = valid_i && !stall_o;
        result_valid_o = (count_q != 2'd0);
        result_o       = fifo_res_q[rd_ptr_q];
        result_stage_o = fifo_stg_q[rd_ptr_q];
        overflow_o     = fifo_ovf_q[rd_ptr_q];
        busy_o         = (state_q == ACCUM) || s1_valid_q || result_valid_o;
    end

    // S1 capture; fin is qualified by accept so it only counts real beats.
    always_comb begin
        s1_valid_d = w_accept;
        s1_fin_d   = w_accept && finished_i;
        s1_stage_d = w_accept ? stage_i : s1_stage_q;
        s1_prod_d  = w_accept ? w_prod  : s1_prod_q;
    end

    // S2 saturating add: one guard bit detects overflow, then clamp.
    always_comb begin
        w_base    = (state_q == ACCUM) ? acc_q : '0;
        w_sum     = {w_base[ACC_W-1], w_base} + {s1_prod_q[ACC_W-1], s1_prod_q};
        w_clamped = w_sum[ACC_W] ^ w_sum[ACC_W-1];
        if (w_clamped) begin
            w_sat = w_sum[ACC_W] ? C_ACC_MIN : C_ACC_MAX;
        end else begin
            w_sat = w_sum[ACC_W-1:0];
        end
    end

    // Accumulator FSM: a finished beat closes the vector and pushes it.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        w_push  = 1'b0;
        if (s1_valid_q) begin
            if (s1_fin_q) begin
                w_push  = 1'b1;
                acc_d   = '0;
                ovf_d   = 1'b0;
                state_d = IDLE;
            end else begin
                acc_d   = w_sat;
                ovf_d   = ovf_q | w_clamped;
                state_d = ACCUM;
            end
        end
    end

    // FIFO bookkeeping; the credit rule keeps a push from ever meeting a full FIFO.
    always_comb begin
        fifo_res_d = fifo_res_q;
        fifo_stg_d = fifo_stg_q;
        fifo_ovf_d = fifo_ovf_q;
        if (w_push) begin
            fifo_res_d[wr_ptr_q] = w_sat;
            fifo_stg_d[wr_ptr_q] = s1_stage_q;
            fifo_ovf_d[wr_ptr_q] = ovf_q | w_clamped;
        end
        wr_ptr_d = wr_ptr_q ^ w_push;
        rd_ptr_d = rd_ptr_q ^ w_pop;
        count_d  = count_q + {1'b0, w_push} - {1'b0, w_pop};
    end

    // State registers with asynchronous clear.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            s1_valid_q <= 1'b0;
            s1_fin_q   <= 1'b0;
            s1_stage_q <= '0;
            s1_prod_q  <= '0;
            state_q    <= IDLE;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_res_q[i] <= '0;
                fifo_stg_q[i] <= '0;
                fifo_ovf_q[i] <= 1'b0;
            end
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_fin_q   <= s1_fin_d;
            s1_stage_q <= s1_stage_d;
            s1_prod_q  <= s1_prod_d;
            state_q    <= state_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fifo_res_q <= fifo_res_d;
            fifo_stg_q <= fifo_stg_d;
            fifo_ovf_q <= fifo_ovf_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage3.sv
// ============================================================================
// Module      : tb_pipe_stage3
// Description : Self-checking bench for pipe_stage3 (ACC_W=32). A per-pair
//               dot-product model with a timed result queue predicts every
//               output each cycle; directed vectors pin literal results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage3;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int SW = 4;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic          CLK_i = 1'b0;
    logic          RST_i = 1'b1;
    logic          valid_i = 1'b0;
    logic [DW-1:0] operand1_i = '0;
    logic [DW-1:0] operand2_i = '0;
    logic          mode_i = 1'b0;
    logic [SW-1:0] stage_i = '0;
    logic          finished_i = 1'b0;
    logic          stall_i = 1'b0;
    logic          stall_o;
    logic [AW-1:0] result_o;
    logic          result_valid_o;
    logic [SW-1:0] result_stage_o;
    logic          overflow_o;
    logic          busy_o;

    pipe_stage3 #(
        .DATA_W  (DW),
        .ACC_W   (AW),
        .STAGE_W (SW)
    ) dut (
        .CLK_i          (CLK_i),
        .RST_i          (RST_i),
        .valid_i        (valid_i),
        .operand1_i     (operand1_i),
        .operand2_i     (operand2_i),
        .mode_i         (mode_i),
        .stage_i        (stage_i),
        .finished_i     (finished_i),
        .stall_i        (stall_i),
        .stall_o        (stall_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .result_stage_o (result_stage_o),
        .overflow_o     (overflow_o),
        .busy_o         (busy_o)
    );

    always #5 CLK_i = ~CLK_i;

    typedef struct {
        logic [AW-1:0] res;
        logic [SW-1:0] stg;
        logic          ovf;
        int            cyc;
    } ent_t;

    ent_t   q[$];
    ent_t   got[$];
    ent_t   mon_e;
    int     cyc = 0;
    int     tests = 0;
    int     fails = 0;
    int     acc_cyc = 0;
    bit     stall_seen = 0;
    longint m_acc = 0;
    bit     m_open = 0;
    bit     m_ovf = 0;
    int     n_avail, n_pend;
    bit     ev, ep, es;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: one accepted pair at a time, plain integer arithmetic.
    function automatic void model_accept();
        longint p, s;
        bit     clamp, ov;
        ent_t   e;
        if (mode_i)
            p = longint'($signed(operand1_i[15:8])) * longint'($signed(operand2_i[15:8]))
              + longint'($signed(operand1_i[7:0]))  * longint'($signed(operand2_i[7:0]));
        else
            p = longint'($signed(operand1_i)) * longint'($signed(operand2_i));
        s = (m_open ? m_acc : 64'sd0) + p;
        clamp = 1'b0;
        if (s > MAXV) begin s = MAXV; clamp = 1'b1; end
        else if (s < MINV) begin s = MINV; clamp = 1'b1; end
        ov = (m_open ? m_ovf : 1'b0) | clamp;
        if (finished_i) begin
            e.res = s[31:0];
            e.stg = stage_i;
            e.ovf = ov;
            e.cyc = cyc + 2;
            q.push_back(e);
            m_open = 0; m_acc = 0; m_ovf = 0;
        end else begin
            m_open = 1; m_acc = s; m_ovf = ov;
        end
    endfunction

    always @(posedge CLK_i) cyc <= cyc + 1;

    // Compare process: every cycle, predict valid/stall/head from the model.
    always @(negedge CLK_i) begin
        if (RST_i) begin
            check("rst_result", {32'b0, result_o}, 64'd0);
            check("rst_valid", {63'b0, result_valid_o}, 64'd0);
            check("rst_stage", {60'b0, result_stage_o}, 64'd0);
            check("rst_ovf", {63'b0, overflow_o}, 64'd0);
            check("rst_stall", {63'b0, stall_o}, 64'd0);
            check("rst_busy", {63'b0, busy_o}, 64'd0);
            q.delete();
            m_open = 0; m_acc = 0; m_ovf = 0;
        end else begin
            n_avail = 0;
            n_pend  = 0;
            foreach (q[i]) begin
                if (q[i].cyc <= cyc) n_avail++;
                else if (q[i].cyc == cyc + 1) n_pend++;
            end
            ev = (n_avail > 0);
            ep = ev && !stall_i;
            es = (n_avail + n_pend - int'(ep)) >= 2;
            check("result_valid", {63'b0, result_valid_o}, {63'b0, ev});
            check("stall_o", {63'b0, stall_o}, {63'b0, es});
            if (ev && result_valid_o) begin
                check("head_result", {32'b0, result_o}, {32'b0, q[0].res});
                check("head_stage", {60'b0, result_stage_o}, {60'b0, q[0].stg});
                check("head_ovf", {63'b0, overflow_o}, {63'b0, q[0].ovf});
            end
            if (stall_o) stall_seen = 1;
            if (ep) begin
                mon_e.res = result_o;
                mon_e.stg = result_stage_o;
                mon_e.ovf = overflow_o;
                mon_e.cyc = cyc;
                got.push_back(mon_e);
                void'(q.pop_front());
            end
            if (valid_i && !es) model_accept();
        end
    end

    // Present one pair and hold it until accepted (bounded).
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic m,
                        input logic [3:0] st, input logic fin);
        bit ok = 0;
        operand1_i = a; operand2_i = b; mode_i = m; stage_i = st; finished_i = fin;
        valid_i = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge CLK_i);
            if (!stall_o) begin ok = 1; acc_cyc = cyc; end
            @(posedge CLK_i); #1;
            if (ok) break;
        end
        valid_i = 1'b0;
        if (!ok) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge CLK_i);
            if (!result_valid_o && !busy_o && q.size() == 0) begin ok = 1; break; end
        end
        check("idle_reached", {63'b0, ok}, 64'd1);
        @(posedge CLK_i); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fin_cyc;
        repeat (3) @(posedge CLK_i);
        #1 RST_i = 1'b0;
        @(posedge CLK_i); #1;

        // Full-mode vector: 12 - 10 + 49 = 51
        got.delete();
        send(16'd3, 16'd4, 1'b0, 4'd5, 1'b0);
        send(16'hFFFE, 16'd5, 1'b0, 4'd5, 1'b0);
        send(16'd7, 16'd7, 1'b0, 4'd5, 1'b1);
        fin_cyc = acc_cyc;
        wait_idle();
        check("full_count", got.size(), 64'd1);
        if (got.size() == 1) begin
            check("full_result", {32'b0, got[0].res}, 64'd51);
            check("full_stage", {60'b0, got[0].stg}, 64'd5);
            check("full_ovf", {63'b0, got[0].ovf}, 64'd0);
            check("full_latency", 64'(got[0].cyc), 64'(fin_cyc + 2));
        end

        // Dual-mode products: 2*4+3*5 = 23 ; -1*2+3*5 = 13
        got.delete();
        send(16'h0203, 16'h0405, 1'b1, 4'd2, 1'b1);
        send(16'hFF03, 16'h0205, 1'b1, 4'd3, 1'b1);
        wait_idle();
        check("dual_count", got.size(), 64'd2);
        if (got.size() == 2) begin
            check("dual_res0", {32'b0, got[0].res}, 64'd23);
            check("dual_res1", {32'b0, got[1].res}, 64'd13);
        end

        // Backpressure: two buffered, third held off until release
        got.delete();
        stall_i = 1'b1;
        send(16'd10, 16'd1, 1'b0, 4'd1, 1'b1);
        send(16'd20, 16'd1, 1'b0, 4'd2, 1'b1);
        fork
            send(16'd30, 16'd1, 1'b0, 4'd3, 1'b1);
            begin
                repeat (4) @(negedge CLK_i);
                check("bp_stall_high", {63'b0, stall_o}, 64'd1);
                check("bp_head_valid", {63'b0, result_valid_o}, 64'd1);
                check("bp_head_hold", {32'b0, result_o}, 64'd10);
                @(posedge CLK_i); #1;
                stall_i = 1'b0;
            end
        join
        wait_idle();
        check("bp_count", got.size(), 64'd3);
        if (got.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("bp_order_res", {32'b0, got[i].res}, 64'(10 * (i + 1)));
                check("bp_order_stg", {60'b0, got[i].stg}, 64'(i + 1));
            end
        end

        // Saturation, then a clean vector
        got.delete();
        send(16'h7FFF, 16'h7FFF, 1'b0, 4'd7, 1'b0);
        send(16'h7FFF, 16'h7FFF, 1'b0, 4'd7, 1'b0);
        send(16'h7FFF, 16'h7FFF, 1'b0, 4'd7, 1'b1);
        send(16'd1, 16'd1, 1'b0, 4'd8, 1'b1);
        wait_idle();
        check("sat_count", got.size(), 64'd2);
        if (got.size() == 2) begin
            check("sat_result", {32'b0, got[0].res}, 64'h7FFFFFFF);
            check("sat_ovf", {63'b0, got[0].ovf}, 64'd1);
            check("post_sat_result", {32'b0, got[1].res}, 64'd1);
            check("post_sat_ovf", {63'b0, got[1].ovf}, 64'd0);
        end

        // Reset mid-vector discards the partial sum
        got.delete();
        send(16'd5, 16'd5, 1'b0, 4'd4, 1'b0);
        send(16'd5, 16'd5, 1'b0, 4'd4, 1'b0);
        RST_i = 1'b1;
        #1;
        check("mid_rst_busy", {63'b0, busy_o}, 64'd0);
        check("mid_rst_valid", {63'b0, result_valid_o}, 64'd0);
        @(posedge CLK_i); #1;
        RST_i = 1'b0;
        send(16'd1, 16'd1, 1'b0, 4'd9, 1'b1);
        wait_idle();
        check("rst_vec_count", got.size(), 64'd1);
        if (got.size() == 1) begin
            check("rst_vec_result", {32'b0, got[0].res}, 64'd1);
            check("rst_vec_stage", {60'b0, got[0].stg}, 64'd9);
        end

        // Full rate: one result per cycle, no stall
        got.delete();
        stall_seen = 0;
        for (int i = 0; i < 8; i++) send(16'(i), 16'd1, 1'b0, 4'(i), 1'b1);
        wait_idle();
        check("rate_stall_seen", {63'b0, stall_seen}, 64'd0);
        check("rate_count", got.size(), 64'd8);
        if (got.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("rate_result", {32'b0, got[i].res}, 64'(i));
                check("rate_cycle", 64'(got[i].cyc), 64'(got[0].cyc + i));
            end
        end

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            valid_i    = ($urandom_range(0, 3) != 0);
            mode_i     = $urandom_range(0, 1) == 1;
            finished_i = ($urandom_range(0, 3) == 0);
            stage_i    = 4'($urandom);
            stall_i    = ($urandom_range(0, 9) < 3);
            case ($urandom_range(0, 3))
                0: begin operand1_i = 16'h7FFF; operand2_i = 16'h7FFF; end
                1: begin operand1_i = 16'h8000; operand2_i = 16'h7FFF; end
                default: begin operand1_i = 16'($urandom); operand2_i = 16'($urandom); end
            endcase
            @(posedge CLK_i); #1;
        end
        valid_i = 1'b0;
        stall_i = 1'b0;
        send(16'd0, 16'd0, 1'b0, 4'd0, 1'b1);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
